// File: rtl/seven_seg_scan_driver.sv
// Scan driver for a 4-digit seven-segment display with frame-aligned value commits.
// Optional leading-zero blanking: define SEVEN_SEG_SCAN_LZB_EN.
module seven_seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  input  logic        load,
  input  logic [15:0] value_in,
  output logic [1:0]  en,
  output logic [3:0]  num,
  output logic        blank_digit,
  output logic        frame_done,
  output logic        update_pending
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST =
    CW'(REFRESH_DIV - 1);

  logic [CW-1:0] r_div_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_num;
  logic [15:0]   r_disp;
  logic [15:0]   r_pend;
  logic          r_upd;
  logic          r_fd;

  logic          w_tick;
  logic          w_wrap;
  logic          w_commit;
  logic [1:0]    w_idx_nxt;
  logic [15:0]   w_disp_nxt;
  logic [3:0]    w_num_nxt;

  assign w_tick     = scan_en && (r_div_cnt == DIV_LAST);
  assign w_wrap     = w_tick && (r_idx == 2'd3);
  assign w_commit   = w_wrap && r_upd;
  assign w_idx_nxt  = w_tick ? r_idx + 2'd1 : r_idx;
  assign w_disp_nxt = w_commit ? r_pend : r_disp;

  always_comb begin
    w_num_nxt = w_disp_nxt[3:0];
    unique case (w_idx_nxt)
      2'd0: w_num_nxt = w_disp_nxt[3:0];
      2'd1: w_num_nxt = w_disp_nxt[7:4];
      2'd2: w_num_nxt = w_disp_nxt[11:8];
      2'd3: w_num_nxt = w_disp_nxt[15:12];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (scan_en) begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + CW'(1);
    end
  end

  // en/num are refreshed from next-state values so they track idx/disp with no skew
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= 2'd0;
      r_num  <= 4'd0;
      r_disp <= 16'd0;
      r_fd   <= 1'b0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_num  <= w_num_nxt;
      r_disp <= w_disp_nxt;
      r_fd   <= w_wrap;
    end
  end

  // A load in the boundary cycle wins the pending flag for the following frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= 16'd0;
      r_upd  <= 1'b0;
    end else if (load) begin
      r_pend <= value_in;
      r_upd  <= 1'b1;
    end else if (w_wrap) begin
      r_upd  <= 1'b0;
    end
  end

`ifdef SEVEN_SEG_SCAN_LZB_EN
  logic       r_blank;
  logic [1:0] w_msd;

  always_comb begin
    w_msd = 2'd0;
    if (w_disp_nxt[15:12] != 4'd0)
      w_msd = 2'd3;
    else if (w_disp_nxt[11:8] != 4'd0)
      w_msd = 2'd2;
    else if (w_disp_nxt[7:4] != 4'd0)
      w_msd = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_blank <= 1'b0;
    else     r_blank <= (w_idx_nxt > w_msd);
  end

  assign blank_digit = r_blank;
`else
  assign blank_digit = 1'b0;
`endif

  assign en             = r_idx;
  assign num            = r_num;
  assign frame_done     = r_fd;
  assign update_pending = r_upd;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: vector table, corner sequences, random vs model.
// Runs two instances (REFRESH_DIV=4 and REFRESH_DIV=1) on shared stimulus.
module tb_seven_seg_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        scan = 1'b0;
  logic        ld = 1'b0;
  logic [15:0] val = 16'd0;

  logic [1:0] en_a, en_b;
  logic [3:0] num_a, num_b;
  logic       bl_a, bl_b, fd_a, fd_b, up_a, up_b;

  seven_seg_scan_driver #(.REFRESH_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .scan_en(scan),
    .load(ld), .value_in(val),
    .en(en_a), .num(num_a), .blank_digit(bl_a),
    .frame_done(fd_a), .update_pending(up_a)
  );

  seven_seg_scan_driver #(.REFRESH_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .scan_en(scan),
    .load(ld), .value_in(val),
    .en(en_b), .num(num_b), .blank_digit(bl_b),
    .frame_done(fd_b), .update_pending(up_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%h exp=%h",
               nm, $time, act, exp);
    end
  endtask

  // Reference: scan position is elapsed scan cycles since reset
  longint      mt[2];
  logic [15:0] md[2], mp[2];
  bit          mu[2], mf[2];
  int          dv[2] = '{4, 1};

  function automatic logic [1:0] m_en(int k);
    return 2'((mt[k] / dv[k]) % 4);
  endfunction

  function automatic logic [3:0] m_num(int k);
    return 4'(md[k] >> (4 * m_en(k)));
  endfunction

  function automatic bit m_blank(int k);
`ifdef SEVEN_SEG_SCAN_LZB_EN
    int top;
    top = 0;
    for (int j = 0; j < 4; j++)
      if (((md[k] >> (4 * j)) & 16'hF) != 0) top = j;
    return int'(m_en(k)) > top;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    bit bd;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mt[k] = 0; md[k] = 0; mp[k] = 0;
        mu[k] = 0; mf[k] = 0;
      end else begin
        bd = scan &&
             (mt[k] % (4 * dv[k]) == 4 * dv[k] - 1);
        mf[k] = bd;
        if (bd && mu[k]) md[k] = mp[k];
        if (ld) begin
          mp[k] = val; mu[k] = 1;
        end else if (bd) mu[k] = 0;
        if (scan) mt[k]++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("a_en",  32'(en_a),  32'(m_en(0)));
    chk("a_num", 32'(num_a), 32'(m_num(0)));
    chk("a_fd",  32'(fd_a),  32'(mf[0]));
    chk("a_up",  32'(up_a),  32'(mu[0]));
    chk("a_bl",  32'(bl_a),  32'(m_blank(0)));
    chk("b_en",  32'(en_b),  32'(m_en(1)));
    chk("b_num", 32'(num_b), 32'(m_num(1)));
    chk("b_fd",  32'(fd_b),  32'(mf[1]));
    chk("b_up",  32'(up_b),  32'(mu[1]));
    chk("b_bl",  32'(bl_b),  32'(m_blank(1)));
  endtask

  typedef struct {
    bit          r, s, l;
    logic [15:0] v;
    logic [1:0]  en;
    logic [3:0]  num;
    bit          fd, up;
  } vec_t;

  vec_t tv[33];

  task automatic fill(input int lo, input int hi,
                      input vec_t v);
    for (int i = lo; i <= hi; i++) tv[i] = v;
  endtask

  int cnt;
  logic [3:0] bexp[4];

  initial begin
    // Reset/scan with a mid-frame load of 1234 (REFRESH_DIV=4)
    fill(0,  0,  '{1,1,0,16'h0,0,0,0,0});
    fill(1,  5,  '{0,1,0,16'h0,0,0,0,0});
    fill(4,  5,  '{0,1,0,16'h0,1,0,0,0});
    fill(6,  6,  '{0,1,1,16'h1234,1,0,0,1});
    fill(7,  7,  '{0,1,0,16'h0,1,0,0,1});
    fill(8,  11, '{0,1,0,16'h0,2,0,0,1});
    fill(12, 15, '{0,1,0,16'h0,3,0,0,1});
    fill(16, 16, '{0,1,0,16'h0,0,4,1,0});
    fill(17, 19, '{0,1,0,16'h0,0,4,0,0});
    fill(20, 23, '{0,1,0,16'h0,1,3,0,0});
    fill(24, 27, '{0,1,0,16'h0,2,2,0,0});
    fill(28, 31, '{0,1,0,16'h0,3,1,0,0});
    fill(32, 32, '{0,1,0,16'h0,0,4,1,0});

    for (int i = 0; i < 33; i++) begin
      rst = tv[i].r; scan = tv[i].s;
      ld = tv[i].l; val = tv[i].v;
      step();
      chk("tv_en",  32'(en_a),  32'(tv[i].en));
      chk("tv_num", 32'(num_a), 32'(tv[i].num));
      chk("tv_fd",  32'(fd_a),  32'(tv[i].fd));
      chk("tv_up",  32'(up_a),  32'(tv[i].up));
    end
    rst = 0; ld = 0;

    // Load collides with frame boundary
    ld = 1; val = 16'hAAAA;
    step();
    ld = 0;
    cnt = 0;
    while (mt[0] % 16 != 15 && cnt < 40) begin
      step(); cnt++;
    end
    chk("coll_wait", 32'(cnt < 40), 32'd1);
    ld = 1; val = 16'h5555;
    step();
    ld = 0;
    chk("coll_fd",  32'(fd_a),  32'd1);
    chk("coll_num", 32'(num_a), 32'hA);
    chk("coll_up",  32'(up_a),  32'd1);
    repeat (16) step();
    chk("coll2_fd",  32'(fd_a),  32'd1);
    chk("coll2_num", 32'(num_a), 32'h5);
    chk("coll2_up",  32'(up_a),  32'd0);

    // Freeze one cycle into digit 2
    cnt = 0;
    while (!(mt[0] % 16 == 9) && cnt < 40) begin
      step(); cnt++;
    end
    chk("frz_wait", 32'(cnt < 40), 32'd1);
    scan = 0;
    for (int i = 0; i < 10; i++) begin
      ld = (i == 5); val = 16'h0F0F;
      step();
      chk("frz_en", 32'(en_a), 32'd2);
      chk("frz_fd", 32'(fd_a), 32'd0);
      chk("frz_nm", 32'(num_a), 32'h5);
    end
    ld = 0;
    chk("frz_up", 32'(up_a), 32'd1);
    scan = 1;
    cnt = 0;
    while (en_a == 2'd2 && cnt < 10) begin
      step(); cnt++;
    end
    chk("frz_rest", 32'(cnt), 32'd3);

    // Reset discards a pending value
    ld = 1; val = 16'hBEEF;
    step();
    ld = 0; rst = 1;
    step();
    rst = 0;
    chk("rst_up", 32'(up_a), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      scan = ($urandom_range(0, 7) != 0);
      ld   = ($urandom_range(0, 7) == 0);
      val  = 16'($urandom);
      step();
    end

    // Leading-zero blanking on 00A5 then 0000
`ifdef SEVEN_SEG_SCAN_LZB_EN
    bexp = '{4'd0, 4'd0, 4'd1, 4'd1};
`else
    bexp = '{4'd0, 4'd0, 4'd0, 4'd0};
`endif
    scan = 1; ld = 0; rst = 1;
    step();
    rst = 0; ld = 1; val = 16'h00A5;
    step();
    ld = 0;
    cnt = 0;
    while (up_a && cnt < 40) begin
      step(); cnt++;
    end
    chk("lzb_wait", 32'(cnt < 40), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("lzb_a5", 32'(bl_a), 32'(bexp[en_a][0]));
    end
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      step();
`ifdef SEVEN_SEG_SCAN_LZB_EN
      chk("lzb_00", 32'(bl_a), 32'(en_a != 2'd0));
`else
      chk("lzb_00", 32'(bl_a), 32'd0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Time-multiplexing scan driver that feeds the 4-digit seven-segment decoder-with-enable.
- Holds a 16-bit display value and rotates the 2-bit digit select `en` through digits 0..3 at a programmable refresh rate.
- Presents the matching nibble on `num` for each digit.
- New values are double-buffered and committed only at frame boundaries, so the display never tears mid-frame.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit is held (dwell); legal range 1..2^24-1. The counter width is derived from this value.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- scan_en  input  1  1 = scanning advances; 0 = counter and outputs freeze.
- load  input  1  single-cycle strobe; captures value_in into the pending buffer.
- value_in  input  16  display value; nibble k goes to digit k (digit 0 = bits 3:0).
- en  output  2  digit select to the decoder (0..3).
- num  output  4  nibble for the currently selected digit.
- blank_digit  output  1  1 = current digit should be blanked (see Optional Feature).
- frame_done  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.
- update_pending  output  1  1 = a loaded value is waiting for the next frame boundary.

Behaviour:
- Reset (rst=1 at a clock edge):
  - div_cnt=0, idx=0, en=0, num=0, disp=0, pend=0.
  - update_pending=0, frame_done=0, blank_digit=0.
  - Reset mid-frame discards any pending value.
- Divider:
  - When scan_en=1, div_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick is asserted combinationally when scan_en=1 and div_cnt==REFRESH_DIV-1.
  - With REFRESH_DIV=1, tick is asserted every scan_en cycle.
- Digit index: on tick, idx <= idx+1 modulo 4 (3 wraps to 0).
- Registered outputs:
  - en and num are registered and reflect the next idx.
  - A tick at edge N produces new en/num visible after edge N (1-cycle latency from tick).
  - num = disp nibble at position en, using the disp value in effect after the same edge.
- Frame boundary:
  - Occurs on a tick with idx==3.
  - frame_done pulses high for exactly one cycle, aligned with en becoming 0.
  - If update_pending=1 at the boundary: disp <= pend and update_pending <= 0. The new value appears starting with digit 0 of the new frame.
- Load:
  - load=1 captures value_in into pend and sets update_pending=1, regardless of scan_en.
  - Back-to-back loads overwrite pend; the last value wins.
- Simultaneous load and boundary:
  - The boundary commits the old pend contents to disp.
  - pend takes the new value_in; update_pending stays 1 for the next frame.
  - If no load was pending before this cycle, disp is unchanged and the new value waits one full frame.
- scan_en=0:
  - div_cnt, idx, en, num and disp all hold.
  - frame_done=0 and no commit occurs.
  - load still updates pend.
- en only ever takes the values 0..3; no invalid select is produced.

Optional Feature:
- Macro: SEVEN_SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - blank_digit is registered with en/num.
  - blank_digit=1 when the current digit is above the most significant nonzero nibble of disp.
  - Digit 0 is never blanked, so disp=0 shows a single "0".
  - Example: disp=16'h00A5 gives digits 3 and 2 blanked, digits 1 and 0 shown.
- Undefined: blank_digit is tied to 0 and the blanking logic is not synthesized.

Test Plan:
- Reset/scan: REFRESH_DIV=4, scan_en=1, rst pulse, then 20 cycles.
  - en must sequence 0,1,2,3,0, each value held exactly 4 cycles.
  - All outputs must be 0 during reset and on the first cycle after.
- Buffered update: load value_in=16'h1234 mid-frame while disp=0.
  - update_pending=1 immediately; num stays 0 until the wrap.
  - At the frame_done pulse: update_pending=0.
  - Then num follows en: en=0 gives 4, en=1 gives 3, en=2 gives 2, en=3 gives 1.
- Load/boundary collision: pend=16'hAAAA pending, then load 16'h5555 in the boundary cycle.
  - That frame shows AAAA; update_pending stays 1.
  - The next frame shows 5555.
- Freeze: deassert scan_en for 10 cycles during en=2.
  - en, num and div_cnt hold; no frame_done; a load there only sets update_pending.
  - Resuming completes the remaining dwell of digit 2.
- Divider edge: REFRESH_DIV=1.
  - en changes every cycle.
  - frame_done pulses every 4 cycles.
- LZB (macro defined), disp=16'h00A5: blank_digit=1 at en=3 and en=2, 0 at en=1 and en=0.
- LZB with disp=16'h0000: blank only at en=1..3.
